// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the lane pipeline registers.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Width of a packed lane bus: lane i lives at [i*dw +: dw].
  function automatic int unsigned lane_bus_w(input int unsigned lanes, input int unsigned dw);
    return lanes * dw;
  endfunction

endpackage

// File: rtl/plreg_slot.sv
// One group register: LANES valid bits plus LANES*DW payload.
// Invalid lanes capture zero data.
module plreg_slot
  import pipe_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned DW    = 64
) (
  input  logic                              clk,
  input  logic                              clr_all,
  input  logic                              clr_valid,
  input  logic                              load,
  input  logic [LANES-1:0]                  d_valid,
  input  logic [lane_bus_w(LANES, DW)-1:0]  d_data,
  output logic [LANES-1:0]                  q_valid,
  output logic [lane_bus_w(LANES, DW)-1:0]  q_data
);

  localparam int unsigned BW = lane_bus_w(LANES, DW);

  logic [BW-1:0] masked;

  always_comb begin
    masked = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (d_valid[i]) masked[i*DW +: DW] = d_data[i*DW +: DW];
    end
  end

  // clr_all wins over clr_valid, which wins over load; clr_valid keeps payload.
  always_ff @(posedge clk) begin
    if (clr_all) begin
      q_valid <= '0;
      q_data  <= '0;
    end else if (clr_valid) begin
      q_valid <= '0;
    end else if (load) begin
      q_valid <= d_valid;
      q_data  <= masked;
    end
  end

endmodule

// File: rtl/plreg_skid_lanes.sv
// Multi-lane valid/ready pipeline register with group flush.
// PLREG_SKID_EN adds a skid slot so in_ready is a pure state decode.
module plreg_skid_lanes
  import pipe_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned DW    = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [LANES-1:0]                  in_valid,
  input  logic [lane_bus_w(LANES, DW)-1:0]  in_data,
  output logic                              in_ready,
  output logic [LANES-1:0]                  out_valid,
  output logic [lane_bus_w(LANES, DW)-1:0]  out_data,
  input  logic                              out_ready,
  output logic [1:0]                        occupancy
);

  localparam int unsigned BW = lane_bus_w(LANES, DW);
`ifdef PLREG_SKID_EN
  localparam logic SKID_EN = ENABLE;
`else
  localparam logic SKID_EN = DISABLE;
`endif

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_TWO   = ST_TWO
  } state_t;

  state_t           state;
  logic             in_fire;
  logic             out_fire;
  logic             h_load;
  logic             h_drain;
  logic [LANES-1:0] h_d_valid;
  logic [BW-1:0]    h_d_data;
  logic [LANES-1:0] h_valid;
  logic [BW-1:0]    h_data;
`ifdef PLREG_SKID_EN
  logic             s_load;
  logic             s_drain;
  logic [LANES-1:0] s_valid;
  logic [BW-1:0]    s_data;

  assign in_ready = (state != S_TWO) & ~rst;
`else
  assign in_ready = ~rst & (~(|h_valid) | out_ready);
`endif

  assign in_fire   = (|in_valid) & in_ready;
  assign out_fire  = (|h_valid) & out_ready;
  assign out_valid = h_valid;
  assign out_data  = h_data;

  // Slot load/drain controls decoded from state and handshakes.
  always_comb begin
    h_load    = 1'b0;
    h_drain   = 1'b0;
    h_d_valid = in_valid;
    h_d_data  = in_data;
`ifdef PLREG_SKID_EN
    s_load    = 1'b0;
    s_drain   = 1'b0;
`endif
    case (state)
      S_EMPTY: h_load = in_fire;
      S_ONE: begin
        if (in_fire && out_fire) h_load = 1'b1;
        else if (out_fire)       h_drain = 1'b1;
`ifdef PLREG_SKID_EN
        else if (in_fire)        s_load = 1'b1;
`endif
      end
`ifdef PLREG_SKID_EN
      S_TWO: begin
        if (out_fire) begin
          h_load    = 1'b1;
          h_d_valid = s_valid;
          h_d_data  = s_data;
          s_drain   = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Group-count state; flush empties everything but leaves payload bits.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (in_fire) state <= S_ONE;
        S_ONE: begin
          if (in_fire && !out_fire && (SKID_EN == ENABLE)) state <= S_TWO;
          else if (!in_fire && out_fire)                   state <= S_EMPTY;
        end
        S_TWO:   if (out_fire) state <= S_ONE;
        default: state <= S_EMPTY;
      endcase
    end
  end

  always_comb begin
    case (state)
      S_ONE:   occupancy = 2'd1;
      S_TWO:   occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  plreg_slot #(.LANES(LANES), .DW(DW)) u_head (
    .clk       (clk),
    .clr_all   (rst),
    .clr_valid (flush | h_drain),
    .load      (h_load),
    .d_valid   (h_d_valid),
    .d_data    (h_d_data),
    .q_valid   (h_valid),
    .q_data    (h_data)
  );

`ifdef PLREG_SKID_EN
  plreg_slot #(.LANES(LANES), .DW(DW)) u_skid (
    .clk       (clk),
    .clr_all   (rst),
    .clr_valid (flush | s_drain),
    .load      (s_load),
    .d_valid   (in_valid),
    .d_data    (in_data),
    .q_valid   (s_valid),
    .q_data    (s_data)
  );
`endif

endmodule

// File: tb/tb_plreg_skid_lanes.sv
// Self-checking bench for plreg_skid_lanes against a queue-based group model.
module tb_plreg_skid_lanes;

  localparam int unsigned LANES = 2;
  localparam int unsigned DW    = 64;
  localparam int unsigned BW    = LANES * DW;
`ifdef PLREG_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [LANES-1:0] in_valid;
  logic [BW-1:0]    in_data;
  logic             in_ready;
  logic [LANES-1:0] out_valid;
  logic [BW-1:0]    out_data;
  logic             out_ready;
  logic [1:0]       occupancy;

  plreg_skid_lanes #(.LANES(LANES), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0] v;
    logic [BW-1:0]    d;
  } grp_t;

  grp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic             exp_rdy;
  logic [1:0]       exp_occ;
  logic [LANES-1:0] exp_ov;
  logic [BW-1:0]    exp_od;
  logic             exp_hv;

  function automatic logic [BW-1:0] rand_data();
    logic [BW-1:0] r;
    for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Apply one cycle of inputs, record expected outputs, then advance the model.
  task automatic apply(input logic [LANES-1:0] iv, input logic [BW-1:0] id,
                       input logic ordy, input logic fl, input logic r);
    grp_t g;
    bit   in_f, out_f;
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl; rst = r;
    #1;
    exp_rdy = r ? 1'b0 : ((q.size() < CAP) || (CAP == 1 && ordy));
    exp_occ = 2'(q.size());
    exp_hv  = (q.size() != 0);
    exp_ov  = exp_hv ? q[0].v : '0;
    exp_od  = exp_hv ? q[0].d : '0;
    in_f  = (|iv) && exp_rdy;
    out_f = exp_hv && ordy;
    if (r) q.delete();
    else begin
      if (out_f) void'(q.pop_front());
      if (fl) q.delete();
      else if (in_f) begin
        g.v = iv;
        g.d = '0;
        for (int i = 0; i < LANES; i++) if (iv[i]) g.d[i*DW +: DW] = id[i*DW +: DW];
        q.push_back(g);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 2'b11; in_data = rand_data(); out_ready = 1'b0;
    q.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      vectors++;
      if ({in_ready, out_valid, occupancy} !== {1'b0, 2'b00, 2'd0}) begin
        miscompares++;
        $display("FAIL reset.ctl: rdy/ov/occ got %b/%b/%0d want 0/00/0", in_ready, out_valid, occupancy);
      end
      vectors++;
      if (out_data !== '0) begin
        miscompares++;
        $display("FAIL reset.data: got %h want 0", out_data);
      end
    end
    apply(2'b00, '0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({in_ready, occupancy} !== {1'b1, 2'd0}) begin
      miscompares++;
      $display("FAIL reset.release: rdy/occ got %b/%0d want 1/0", in_ready, occupancy);
    end
  endtask

  task automatic test_streaming();
    logic [BW-1:0] d;
    for (int k = 1; k <= 10; k++) begin
      d = rand_data();
      d[DW-1:0] = 64'(k);
      apply(2'b11, d, 1'b1, 1'b0, 1'b0);
      vectors++;
      if ({in_ready, occupancy, out_valid} !== {exp_rdy, exp_occ, exp_ov}) begin
        miscompares++;
        $display("FAIL stream.ctl[%0d]: rdy/occ/ov got %b/%0d/%b want %b/%0d/%b",
                 k, in_ready, occupancy, out_valid, exp_rdy, exp_occ, exp_ov);
      end
      if (exp_hv) begin
        vectors++;
        if (out_data[DW-1:0] !== 64'(k - 1) || out_data !== exp_od) begin
          miscompares++;
          $display("FAIL stream.data[%0d]: got %h want %h", k, out_data, exp_od);
        end
      end
    end
    apply(2'b00, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [LANES-1:0] iv_t [6] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
    logic             or_t [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      apply(iv_t[k], rand_data(), or_t[k], 1'b0, 1'b0);
      vectors++;
      if ({in_ready, occupancy, out_valid} !== {exp_rdy, exp_occ, exp_ov}) begin
        miscompares++;
        $display("FAIL bp.ctl[%0d]: rdy/occ/ov got %b/%0d/%b want %b/%0d/%b",
                 k, in_ready, occupancy, out_valid, exp_rdy, exp_occ, exp_ov);
      end
      if (exp_hv) begin
        vectors++;
        if (out_data !== exp_od) begin
          miscompares++;
          $display("FAIL bp.data[%0d]: got %h want %h", k, out_data, exp_od);
        end
      end
    end
  endtask

  task automatic test_partial();
    logic [BW-1:0] d;
    d = rand_data();
    d[2*DW-1:DW] = 64'hFFFF;
    apply(2'b01, d, 1'b0, 1'b0, 1'b0);
    apply(2'b00, rand_data(), 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({occupancy, out_valid} !== {2'd1, 2'b01}) begin
      miscompares++;
      $display("FAIL partial.ctl: occ/ov got %0d/%b want 1/01", occupancy, out_valid);
    end
    vectors++;
    if (out_data[2*DW-1:DW] !== 64'h0 || out_data[DW-1:0] !== d[DW-1:0]) begin
      miscompares++;
      $display("FAIL partial.data: got %h want %h", out_data, {64'h0, d[DW-1:0]});
    end
    apply(2'b00, '0, 1'b1, 1'b0, 1'b0);
    apply(2'b00, '0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({occupancy, out_valid} !== {2'd0, 2'b00}) begin
      miscompares++;
      $display("FAIL partial.drain: occ/ov got %0d/%b want 0/00", occupancy, out_valid);
    end
  endtask

  task automatic test_flush();
    for (int rep = 0; rep < 2; rep++) begin
      apply(2'b11, rand_data(), 1'b0, 1'b0, 1'b0);
      if (rep == 1) apply(2'b10, rand_data(), 1'b0, 1'b0, 1'b0);
      apply(2'b11, rand_data(), 1'(rep), 1'b1, 1'b0);
      apply(2'b00, '0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if ({in_ready, occupancy, out_valid} !== {1'b1, 2'd0, 2'b00}) begin
        miscompares++;
        $display("FAIL flush.empty[%0d]: rdy/occ/ov got %b/%0d/%b want 1/0/00",
                 rep, in_ready, occupancy, out_valid);
      end
      apply(2'b00, '0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 2'b00) begin
        miscompares++;
        $display("FAIL flush.ghost[%0d]: ov got %b want 00", rep, out_valid);
      end
    end
  endtask

  task automatic test_replace();
    logic [BW-1:0] a, b;
    a = rand_data(); b = rand_data();
    apply(2'b11, a, 1'b0, 1'b0, 1'b0);
    apply(2'b00, '0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (in_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL replace.stall: rdy got %b want %b", in_ready, exp_rdy);
    end
    apply(2'b11, b, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({in_ready, out_data} !== {1'b1, a}) begin
      miscompares++;
      $display("FAIL replace.ready: rdy/data got %b/%h want 1/%h", in_ready, out_data, a);
    end
    apply(2'b00, '0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({occupancy, out_data} !== {2'd1, b}) begin
      miscompares++;
      $display("FAIL replace.next: occ/data got %0d/%h want 1/%h", occupancy, out_data, b);
    end
    apply(2'b00, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [LANES-1:0] iv;
    for (int k = 0; k < 400; k++) begin
      iv = 2'($urandom_range(0, 3));
      apply(iv, rand_data(), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
      vectors++;
      if ({in_ready, occupancy, out_valid} !== {exp_rdy, exp_occ, exp_ov}) begin
        miscompares++;
        $display("FAIL rand.ctl[%0d]: rdy/occ/ov got %b/%0d/%b want %b/%0d/%b",
                 k, in_ready, occupancy, out_valid, exp_rdy, exp_occ, exp_ov);
      end
      if (exp_hv) begin
        vectors++;
        if (out_data !== exp_od) begin
          miscompares++;
          $display("FAIL rand.data[%0d]: got %h want %h", k, out_data, exp_od);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    apply(2'b11, rand_data(), 1'b0, 1'b0, 1'b0);
    apply(2'b11, rand_data(), 1'b0, 1'b0, 1'b0);
    apply(2'b11, rand_data(), 1'b0, 1'b0, 1'b1);
    apply(2'b00, '0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({in_ready, occupancy, out_valid, out_data} !== {1'b1, 2'd0, 2'b00, {BW{1'b0}}}) begin
      miscompares++;
      $display("FAIL rstmid: rdy/occ/ov got %b/%0d/%b data %h want 1/0/00 data 0",
               in_ready, occupancy, out_valid, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_partial();
    test_flush();
    test_replace();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
